clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Consumes the 1 Hz square wave produced by the clock divider and turns it into 24-hour wall-clock time (HH:MM:SS, packed BCD).
- Sits between the divider and the seven-segment display driver, in the same fast clock domain as the divider.
- Provides a set mode for manual hour/minute adjustment.
- Generates one-cycle second and day strobes for downstream blocks.

Parameters:
- RESET_HH, 0, hour loaded on reset (0..23, decimal; stored as BCD).
- RESET_MM, 0, minute loaded on reset (0..59).
- RESET_SS, 0, second loaded on reset (0..59).

Ports:
- clk  in  1  system clock, same clock that drives the divider.
- rst  in  1  asynchronous, active-low reset.
- tick_in  in  1  1 Hz square wave from the divider; synchronous to clk. Rising edge = one second.
- set_en  in  1  level; 1 = set mode, counting frozen.
- inc_min  in  1  synchronous, debounced; each rising edge adds one minute while in set mode.
- inc_hr  in  1  synchronous, debounced; each rising edge adds one hour while in set mode.
- hours  out  8  BCD, [7:4] tens 0..2, [3:0] units.
- minutes  out  8  BCD, [7:4] tens 0..5, [3:0] units.
- seconds  out  8  BCD, [7:4] tens 0..5, [3:0] units.
- sec_pulse  out  1  one-cycle strobe per counted second.
- day_pulse  out  1  one-cycle strobe on 23:59:59 -> 00:00:00.
- alarm  out  1  alarm match (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - hours/minutes/seconds = BCD of RESET_HH/MM/SS.
  - sec_pulse=0, day_pulse=0, alarm=0.
  - All edge-detect history registers = 0, so a tick_in already high at release does not count.
- Edge detection: registered copies tick_d, min_d, hr_d.
  - tick_edge = tick_in & ~tick_d; likewise for inc_min and inc_hr.
  - Only rising edges act. A held-high level never repeats.
- Run mode (set_en=0):
  - On the clk edge that samples tick_edge=1, seconds increments in the same edge. sec_pulse=1 for exactly the following cycle. Latency tick_in rise -> new time = 1 clk edge.
  - Seconds units 9 -> 0 carries to seconds tens. Seconds 59 -> 00 carries to minutes.
  - Minutes 59 -> 00 carries to hours.
  - Hours 23 -> 00. day_pulse=1 in the same cycle as that sec_pulse.
  - BCD digits never hold values above 9. Units and tens are updated together in one edge; no intermediate values are visible.
  - inc_min and inc_hr are ignored.
- Set mode (set_en=1):
  - tick edges are ignored; sec_pulse and day_pulse stay 0.
  - seconds forced to 00 on every cycle.
  - inc_min edge: minutes +1, 59 -> 00, no carry into hours.
  - inc_hr edge: hours +1, 23 -> 00.
  - Both edges in the same cycle: both applied.
- set_en 1 -> 0: counting resumes from HH:MM:00. The first tick edge sampled with set_en=0 is counted. tick_d keeps tracking in set mode, so no spurious count occurs on exit.
- tick edge in the same cycle set_en rises: set mode wins; the tick is dropped.
- Reset mid-operation: asynchronous return to reset values. The first tick rising edge after release (tick_d=0 start) is counted only if tick_in is sampled low at least once first. An already-high tick_in at release is captured into tick_d without counting. Required implementation: tick_d loads tick_in on the first post-reset edge while counting is suppressed for that cycle via a one-bit arm flag, reset 0, set 1 after the first edge.
- Parameter values out of range are illegal; behaviour is unspecified.

Optional Feature:
- Macro ALARM_EN.
- Defined:
  - Adds inputs alarm_on (1), alarm_hh (8, BCD) and alarm_mm (8, BCD).
  - alarm is registered: 1 the cycle after alarm_on=1, set_en=0, hours==alarm_hh and minutes==alarm_mm all hold.
  - It stays high for the whole matching minute and clears within one cycle of any condition failing.
- Not defined:
  - No extra ports; alarm is tied to 0.

Test Plan:
- Reset with defaults, then 3 tick_in rising edges -> outputs 00:00:03; exactly 3 sec_pulse cycles, each the cycle after its edge.
- RESET_HH=23, RESET_MM=59, RESET_SS=58, then 2 ticks -> 23:59:59, then 00:00:00; day_pulse high one cycle coincident with the 2nd sec_pulse.
- From 12:34:56, set_en=1 -> seconds 00. Toggle inc_min 30 times -> minutes 04 (wraps), hours still 12. Toggle inc_hr 12 times -> hours 00. Ticks during set produce no change.
- inc_min held high 100 cycles in set mode -> exactly one increment. Simultaneous inc_min and inc_hr edges from 23:59 -> 00:00.
- rst asserted mid-count while tick_in high, released while high -> time = reset values and no count until the next low->high transition. With ALARM_EN, alarm 07:30, running through 07:29:59 -> alarm rises one cycle after 07:30:00 appears and falls after 07:31:00.

Source files
------------

// File: rtl/clock_time_counter.sv
// 24-hour BCD wall clock driven by the 1 Hz divider output, with a manual set mode.
// Optional macro ALARM_EN adds an hour/minute alarm comparator; without it alarm is tied low.
module clock_time_counter #(
  parameter int RESET_HH = 0,
  parameter int RESET_MM = 0,
  parameter int RESET_SS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
`ifdef ALARM_EN
  input  logic       alarm_on,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
`endif
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       alarm
);

  localparam logic [7:0] RST_HH_BCD = 8'(((RESET_HH / 10) * 16) + (RESET_HH % 10));
  localparam logic [7:0] RST_MM_BCD = 8'(((RESET_MM / 10) * 16) + (RESET_MM % 10));
  localparam logic [7:0] RST_SS_BCD = 8'(((RESET_SS / 10) * 16) + (RESET_SS % 10));

  // Two-digit BCD increment that wraps to 00 after reaching top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [7:0] hours_q, hours_d;
  logic [7:0] minutes_q, minutes_d;
  logic [7:0] seconds_q, seconds_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       day_pulse_q, day_pulse_d;
  logic       tick_hist_q, min_hist_q, hr_hist_q;
  logic       arm_q;
  logic       tick_edge, min_edge, hr_edge;

  // arm_q blanks the first post-reset cycle so a tick already high at release is not counted.
  assign tick_edge = tick_in & ~tick_hist_q & arm_q;
  assign min_edge  = inc_min & ~min_hist_q;
  assign hr_edge   = inc_hr & ~hr_hist_q;

  always_comb begin
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    if (set_en) begin
      seconds_d = 8'h00;
      if (min_edge) minutes_d = bcd_inc(minutes_q, 8'h59);
      if (hr_edge)  hours_d   = bcd_inc(hours_q, 8'h23);
    end else if (tick_edge) begin
      sec_pulse_d = 1'b1;
      seconds_d   = bcd_inc(seconds_q, 8'h59);
      if (seconds_q == 8'h59) begin
        minutes_d = bcd_inc(minutes_q, 8'h59);
        if (minutes_q == 8'h59) begin
          hours_d = bcd_inc(hours_q, 8'h23);
          if (hours_q == 8'h23) day_pulse_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours_q     <= RST_HH_BCD;
      minutes_q   <= RST_MM_BCD;
      seconds_q   <= RST_SS_BCD;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      tick_hist_q <= 1'b0;
      min_hist_q  <= 1'b0;
      hr_hist_q   <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      tick_hist_q <= tick_in;
      min_hist_q  <= inc_min;
      hr_hist_q   <= inc_hr;
      arm_q       <= 1'b1;
    end
  end

`ifdef ALARM_EN
  logic alarm_q, alarm_d;

  assign alarm_d = alarm_on & ~set_en & (hours_q == alarm_hh) & (minutes_q == alarm_mm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: two instances (default reset and 23:59:58 reset) share stimulus
// and are compared every cycle against a seconds-of-day model, plus literal spot checks.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic rst, tick_in, set_en, inc_min, inc_hr;
  logic [7:0] hours0, minutes0, seconds0, hours1, minutes1, seconds1;
  logic sec_pulse0, day_pulse0, alarm0, sec_pulse1, day_pulse1, alarm1;
`ifdef ALARM_EN
  logic       alarm_on = 1'b1;
  logic [7:0] alarm_hh = 8'h00;
  logic [7:0] alarm_mm = 8'h00;
`endif

  int total = 0;
  int bad = 0;
  int sp_cnt0 = 0;
  int dp_cnt1 = 0;

  localparam int RST_T1 = 23 * 3600 + 59 * 60 + 58;

  always #5 clk = ~clk;

  clock_time_counter dut0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en),
    .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef ALARM_EN
    .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
`endif
    .hours(hours0), .minutes(minutes0), .seconds(seconds0),
    .sec_pulse(sec_pulse0), .day_pulse(day_pulse0), .alarm(alarm0)
  );

  clock_time_counter #(.RESET_HH(23), .RESET_MM(59), .RESET_SS(58)) dut1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en),
    .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef ALARM_EN
    .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
`endif
    .hours(hours1), .minutes(minutes1), .seconds(seconds1),
    .sec_pulse(sec_pulse1), .day_pulse(day_pulse1), .alarm(alarm1)
  );

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
    end
  endtask

  // Model: time as seconds since midnight, pulses and alarm as plain flags.
  int  t_m[2];
  bit  sp_m[2], dp_m[2], al_m[2];
  bit  ptick, pmin, phr, armed;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      t_m[0] = 0;
      t_m[1] = RST_T1;
      for (int k = 0; k < 2; k++) begin
        sp_m[k] = 1'b0; dp_m[k] = 1'b0; al_m[k] = 1'b0;
      end
      ptick = 1'b0; pmin = 1'b0; phr = 1'b0; armed = 1'b0;
    end else begin
      bit te, me, he;
      te = tick_in && !ptick && armed;
      me = inc_min && !pmin;
      he = inc_hr && !phr;
      for (int k = 0; k < 2; k++) begin
        int h, m;
        h = t_m[k] / 3600;
        m = (t_m[k] / 60) % 60;
        al_m[k] = 1'b0;
`ifdef ALARM_EN
        al_m[k] = alarm_on && !set_en && bcd(h) == alarm_hh && bcd(m) == alarm_mm;
`endif
        sp_m[k] = 1'b0;
        dp_m[k] = 1'b0;
        if (set_en) begin
          if (me) m = (m + 1) % 60;
          if (he) h = (h + 1) % 24;
          t_m[k] = h * 3600 + m * 60;
        end else if (te) begin
          t_m[k] = (t_m[k] + 1) % 86400;
          sp_m[k] = 1'b1;
          dp_m[k] = (t_m[k] == 0);
        end
      end
      ptick = tick_in; pmin = inc_min; phr = inc_hr; armed = 1'b1;
    end
  end

  function automatic logic [23:0] exp_time(input int t);
    return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60)};
  endfunction

  initial forever begin
    @(negedge clk);
    chk("time0", {hours0, minutes0, seconds0}, exp_time(t_m[0]));
    chk("flags0", {sec_pulse0, day_pulse0, alarm0}, {sp_m[0], dp_m[0], al_m[0]});
    chk("time1", {hours1, minutes1, seconds1}, exp_time(t_m[1]));
    chk("flags1", {sec_pulse1, day_pulse1, alarm1}, {sp_m[1], dp_m[1], al_m[1]});
    if (sec_pulse0 === 1'b1) sp_cnt0++;
    if (day_pulse1 === 1'b1) dp_cnt1++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_in = 1'b1; cyc(1);
    tick_in = 1'b0; cyc(1);
  endtask

  task automatic do_min();
    inc_min = 1'b1; cyc(1);
    inc_min = 1'b0; cyc(1);
  endtask

  task automatic do_hr();
    inc_hr = 1'b1; cyc(1);
    inc_hr = 1'b0; cyc(1);
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; set_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    #1 rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("reset_time0", {hours0, minutes0, seconds0}, 24'h000000);
    chk("reset_time1", {hours1, minutes1, seconds1}, 24'h235958);
    chk("reset_flags", {sec_pulse0, day_pulse0, sec_pulse1, day_pulse1}, 4'b0000);

    repeat (2) do_tick();
    chk("day_wrap1", {hours1, minutes1, seconds1}, 24'h000000);
    chk("day_pulse_cnt", dp_cnt1, 1);
    do_tick();
    chk("three_ticks0", {hours0, minutes0, seconds0}, 24'h000003);
    chk("sec_pulse_cnt", sp_cnt0, 3);

    // tick rising in the same cycle set_en rises must be dropped
    set_en = 1'b1; tick_in = 1'b1; cyc(1);
    tick_in = 1'b0; cyc(1);
    chk("set_clears_sec", seconds0, 8'h00);
    repeat (12) do_hr();
    repeat (34) do_min();
    set_en = 1'b0; cyc(1);
    repeat (56) do_tick();
    chk("at_123456", {hours0, minutes0, seconds0}, 24'h123456);

    set_en = 1'b1; cyc(2);
    chk("set_sec00", seconds0, 8'h00);
    repeat (30) do_min();
    chk("min_wrap", {hours0, minutes0}, 16'h1204);
    repeat (3) do_tick();
    chk("tick_ignored", {minutes0, seconds0}, 16'h0400);
    repeat (12) do_hr();
    chk("hr_wrap", hours0, 8'h00);
    inc_min = 1'b1; cyc(100);
    inc_min = 1'b0; cyc(1);
    chk("held_min_once", minutes0, 8'h05);
    repeat (23) do_hr();
    repeat (54) do_min();
    chk("at_2359", {hours0, minutes0}, 16'h2359);
    inc_min = 1'b1; inc_hr = 1'b1; cyc(1);
    inc_min = 1'b0; inc_hr = 1'b0; cyc(1);
    chk("both_wrap0", {hours0, minutes0, seconds0}, 24'h000000);
    chk("both_wrap1", {hours1, minutes1, seconds1}, 24'h000000);
    set_en = 1'b0; cyc(1);

    for (int i = 0; i < 3000; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) set_en = ~set_en;
      inc_min = 1'($urandom_range(0, 1));
      inc_hr  = ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    set_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; tick_in = 1'b1;
    cyc(2);
    rst = 1'b0; #1;
    chk("async_reset0", {hours0, minutes0, seconds0}, 24'h000000);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    chk("high_at_release0", {hours0, minutes0, seconds0}, 24'h000000);
    chk("high_at_release1", {hours1, minutes1, seconds1}, 24'h235958);
    tick_in = 1'b0; cyc(1);
    tick_in = 1'b1; cyc(1);
    chk("first_edge0", {hours0, minutes0, seconds0}, 24'h000001);
    chk("first_edge1", {hours1, minutes1, seconds1}, 24'h235959);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
